// File: rtl/rle_word_packer.sv
// rle_word_packer
//   Run-length encodes a stream of 8-bit zig-zag coefficients into
//   (run, level) pairs. Each block is 64 coefficients. The pairs are packed
//   eight to a 112-bit SRAM word, and every block ends with an EOB pair.
//
//   Ports
//     clk         rising-edge clock
//     reset       synchronous, active-low reset
//     coef_in     quantised coefficient, two's complement
//     coef_valid  coef_in valid this cycle
//     coef_ready  packer accepts coef_in this cycle
//     wr_en       one-cycle SRAM write strobe
//     wr_addr     SRAM word address of the current write
//     wr_data     packed word; slot k at [111-14(k-1) -: 14] = {run[5:0], level[7:0]}
//     blk_done    pulses with the write of the word holding a block's EOB
//     addr_wrap   pulses with the first write after the write at address 16383
//
//   Build option
//     RLE_ZRL_EN  defined: a run of 16 or more is split into ZRL pairs (15, 0).
//                 undefined: runs 0..62 encode directly, and run 63 becomes
//                 (62, 0) followed by (0, level).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   ACCEPT | coef_ready high; an accepted coefficient packs its first pair
//   EMIT2  | coef_ready low; drains the queued pairs, one per cycle

module rle_word_packer (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   coef_in,
  input  logic         coef_valid,
  output logic         coef_ready,
  output logic         wr_en,
  output logic [13:0]  wr_addr,
  output logic [111:0] wr_data,
  output logic         blk_done,
  output logic         addr_wrap
);

  localparam logic [13:0] EOB_PAIR = {6'h3F, 8'h00};

  typedef enum logic {ACCEPT = 1'b0, EMIT2 = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [5:0]     pos;
  logic [5:0]     run_cnt;
  logic [2:0]     slot_idx;
  logic [111:0]   word_buf;
  logic [13:0]    addr_cnt;
  logic           wrap_pend;

  // Pending pairs, always emitted in this order: prefix pairs (ZRL or the
  // run-63 split), then the level pair, then EOB.
  logic [1:0]     q_pre_cnt;
  logic [5:0]     q_pre_run;
  logic           q_lvl_v;
  logic [5:0]     q_lvl_run;
  logic [7:0]     q_lvl;
  logic           q_eob;

  logic           accept, is_zero, last_pos;
  logic [1:0]     ld_pre_cnt;
  logic [5:0]     ld_pre_run, ld_lvl_run;

  logic [1:0]     cur_pre_cnt, rem_pre_cnt;
  logic [5:0]     cur_pre_run, cur_lvl_run;
  logic           cur_lvl_v, cur_eob, rem_lvl_v, rem_eob;
  logic [7:0]     cur_lvl;

  logic           pair_v, pair_eob, word_done;
  logic [13:0]    pair;
  logic [111:0]   next_word;

  assign accept   = coef_valid && coef_ready && (state == ACCEPT);
  assign is_zero  = (coef_in == 8'h00);
  assign last_pos = (pos == 6'd63);

`ifdef RLE_ZRL_EN
  always_comb begin
    ld_pre_cnt = is_zero ? 2'd0 : run_cnt[5:4];
    ld_pre_run = 6'd15;
    ld_lvl_run = {2'b00, run_cnt[3:0]};
  end
`else
  // Run 63 is reserved for EOB, so the one run that cannot be coded
  // directly is split into (62, 0) followed by (0, level).
  always_comb begin
    ld_pre_cnt = (!is_zero && run_cnt == 6'd63) ? 2'd1 : 2'd0;
    ld_pre_run = 6'd62;
    ld_lvl_run = (run_cnt == 6'd63) ? 6'd0 : run_cnt;
  end
`endif

  // Effective queue: the freshly loaded pairs when a coefficient is
  // accepted, otherwise whatever is still pending from an earlier one.
  always_comb begin
    cur_pre_cnt = q_pre_cnt;
    cur_pre_run = q_pre_run;
    cur_lvl_v   = q_lvl_v;
    cur_lvl_run = q_lvl_run;
    cur_lvl     = q_lvl;
    cur_eob     = q_eob;
    if (accept) begin
      cur_pre_cnt = ld_pre_cnt;
      cur_pre_run = ld_pre_run;
      cur_lvl_v   = !is_zero;
      cur_lvl_run = ld_lvl_run;
      cur_lvl     = coef_in;
      cur_eob     = last_pos;
    end
  end

  // Pop one pair from the head of the queue and pick the next state.
  always_comb begin
    pair_v      = 1'b0;
    pair_eob    = 1'b0;
    pair        = 14'h0000;
    rem_pre_cnt = cur_pre_cnt;
    rem_lvl_v   = cur_lvl_v;
    rem_eob     = cur_eob;
    if (cur_pre_cnt != 2'd0) begin
      pair_v      = 1'b1;
      pair        = {cur_pre_run, 8'h00};
      rem_pre_cnt = cur_pre_cnt - 2'd1;
    end else if (cur_lvl_v) begin
      pair_v    = 1'b1;
      pair      = {cur_lvl_run, cur_lvl};
      rem_lvl_v = 1'b0;
    end else if (cur_eob) begin
      pair_v   = 1'b1;
      pair_eob = 1'b1;
      pair     = EOB_PAIR;
      rem_eob  = 1'b0;
    end
    state_nxt = (rem_pre_cnt != 2'd0 || rem_lvl_v || rem_eob) ? EMIT2 : ACCEPT;
  end

  // Place the pair into its slot. EOB also pads every later slot with EOB.
  always_comb begin
    next_word = word_buf;
    for (int i = 0; i < 8; i++) begin
      if (pair_v) begin
        if (3'(i) == slot_idx)
          next_word[111-14*i -: 14] = pair;
        else if (pair_eob && (3'(i) > slot_idx))
          next_word[111-14*i -: 14] = EOB_PAIR;
      end
    end
    word_done = pair_v && (pair_eob || slot_idx == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ACCEPT;
      coef_ready <= 1'b0;
      pos        <= 6'd0;
      run_cnt    <= 6'd0;
      slot_idx   <= 3'd0;
      word_buf   <= '0;
      addr_cnt   <= 14'd0;
      wrap_pend  <= 1'b0;
      q_pre_cnt  <= 2'd0;
      q_pre_run  <= 6'd0;
      q_lvl_v    <= 1'b0;
      q_lvl_run  <= 6'd0;
      q_lvl      <= 8'h00;
      q_eob      <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 14'd0;
      wr_data    <= '0;
      blk_done   <= 1'b0;
      addr_wrap  <= 1'b0;
    end else begin
      state      <= state_nxt;
      coef_ready <= (state_nxt == ACCEPT);
      q_pre_cnt  <= rem_pre_cnt;
      q_pre_run  <= cur_pre_run;
      q_lvl_v    <= rem_lvl_v;
      q_lvl_run  <= cur_lvl_run;
      q_lvl      <= cur_lvl;
      q_eob      <= rem_eob;

      if (accept) begin
        pos     <= pos + 6'd1;
        run_cnt <= (!is_zero || last_pos) ? 6'd0 : run_cnt + 6'd1;
      end

      if (pair_v) begin
        word_buf <= next_word;
        slot_idx <= word_done ? 3'd0 : slot_idx + 3'd1;
      end

      wr_en     <= word_done;
      blk_done  <= word_done && pair_eob;
      addr_wrap <= word_done && wrap_pend;
      addr_cnt  <= word_done ? addr_cnt + 14'd1 : addr_cnt;
      if (word_done) begin
        wr_data   <= next_word;
        wr_addr   <= addr_cnt;
        wrap_pend <= (addr_cnt == 14'h3FFF);
      end
    end
  end

endmodule

// File: tb/tb_rle_word_packer.sv
module tb_rle_word_packer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   coef_in = 8'h00;
  logic         coef_valid = 1'b0;
  logic         coef_ready;
  logic         wr_en;
  logic [13:0]  wr_addr;
  logic [111:0] wr_data;
  logic         blk_done;
  logic         addr_wrap;

  rle_word_packer dut (
    .clk        (clk),
    .reset      (reset),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .blk_done   (blk_done),
    .addr_wrap  (addr_wrap)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] EOB = 14'h3F00;
  localparam logic [13:0] ONE = 14'h0001;

  typedef struct packed {
    logic [13:0]  addr;
    logic [111:0] data;
    logic         done;
    logic         wrap;
  } wr_t;

  wr_t        wlog[$];
  int         errors = 0;
  int         checks = 0;
  int         rdy_low = 0;
  logic       cnt_en = 1'b0;
  logic [7:0] blk [64];

  always @(negedge clk) begin
    if (reset && wr_en) begin
      wr_t w;
      w.addr = wr_addr;
      w.data = wr_data;
      w.done = blk_done;
      w.wrap = addr_wrap;
      wlog.push_back(w);
    end
    if (reset && cnt_en && !coef_ready) rdy_low++;
  end

  function automatic logic [111:0] w8(input logic [13:0] s1, s2, s3, s4, s5, s6, s7, s8);
    return {s1, s2, s3, s4, s5, s6, s7, s8};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    coef_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    wlog.delete();
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
  endtask

  task automatic send_coef(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    coef_in = c;
    coef_valid = 1'b1;
    while (!coef_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!coef_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: coef_ready stayed %b, required 1", coef_ready);
    end
    @(posedge clk);
    #1 coef_valid = 1'b0;
  endtask

  task automatic run_block(input int gap);
    for (int i = 0; i < 64; i++) begin
      send_coef(blk[i]);
      repeat (gap) @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    coef_valid = 1'b1;
    coef_in = 8'h11;
    repeat (3) @(negedge clk);
    checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", coef_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 14'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 112'd0) begin errors++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    checks++; if (blk_done !== 1'b0 || addr_wrap !== 1'b0) begin errors++; $display("FAIL rst_pulses: got %b%b want 00", blk_done, addr_wrap); end
    coef_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", coef_ready); end
    repeat (3) @(negedge clk);
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL rst_no_write: got %0d writes want 0", wlog.size()); end
    wlog.delete();
  endtask

  task automatic test_all_zero();
    logic [111:0] exp_w;
    exp_w = w8(EOB, EOB, EOB, EOB, EOB, EOB, EOB, EOB);
    apply_reset();
    clear_blk();
    run_block(0);
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL zero_count: got %0d want 1", wlog.size()); end
    if (wlog.size() >= 1) begin
      checks++; if (wlog[0].addr !== 14'd0) begin errors++; $display("FAIL zero_addr: got %0d want 0", wlog[0].addr); end
      checks++; if (wlog[0].data !== exp_w) begin errors++; $display("FAIL zero_data: got %h want %h", wlog[0].data, exp_w); end
      checks++; if (wlog[0].done !== 1'b1 || wlog[0].wrap !== 1'b0) begin errors++; $display("FAIL zero_flags: got done=%b wrap=%b want 1 0", wlog[0].done, wlog[0].wrap); end
    end
    checks++; if (wr_en !== 1'b0 || wr_data !== exp_w) begin errors++; $display("FAIL zero_hold: got wr_en=%b data=%h want 0 %h", wr_en, wr_data, exp_w); end
  endtask

  task automatic test_two_coef();
    logic [111:0] exp_w;
    exp_w = w8(14'h0005, 14'h00FD, EOB, EOB, EOB, EOB, EOB, EOB);
    apply_reset();
    clear_blk();
    blk[0] = 8'h05;
    blk[1] = 8'hFD;
    run_block(0);
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL two_count: got %0d want 1", wlog.size()); end
    if (wlog.size() >= 1) begin
      checks++; if (wlog[0].addr !== 14'd0) begin errors++; $display("FAIL two_addr: got %0d want 0", wlog[0].addr); end
      checks++; if (wlog[0].data !== exp_w) begin errors++; $display("FAIL two_data: got %h want %h", wlog[0].data, exp_w); end
      checks++; if (wlog[0].done !== 1'b1) begin errors++; $display("FAIL two_done: got %b want 1", wlog[0].done); end
    end
  endtask

  task automatic test_nine_ones_gaps();
    logic [111:0] exp0, exp1;
    exp0 = w8(ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE);
    exp1 = w8(ONE, EOB, EOB, EOB, EOB, EOB, EOB, EOB);
    apply_reset();
    clear_blk();
    for (int i = 0; i < 9; i++) blk[i] = 8'h01;
    run_block(2);
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL nine_count: got %0d want 2", wlog.size()); end
    if (wlog.size() >= 2) begin
      checks++; if (wlog[0].addr !== 14'd0 || wlog[1].addr !== 14'd1) begin errors++; $display("FAIL nine_addr: got %0d,%0d want 0,1", wlog[0].addr, wlog[1].addr); end
      checks++; if (wlog[0].data !== exp0) begin errors++; $display("FAIL nine_data0: got %h want %h", wlog[0].data, exp0); end
      checks++; if (wlog[1].data !== exp1) begin errors++; $display("FAIL nine_data1: got %h want %h", wlog[1].data, exp1); end
      checks++; if (wlog[0].done !== 1'b0 || wlog[1].done !== 1'b1) begin errors++; $display("FAIL nine_done: got %b,%b want 0,1", wlog[0].done, wlog[1].done); end
    end
  endtask

  task automatic test_last_only();
    logic [111:0] exp_w;
    int exp_low;
`ifdef RLE_ZRL_EN
    exp_w = w8(14'h0F00, 14'h0F00, 14'h0F00, 14'h0F01, EOB, EOB, EOB, EOB);
    exp_low = 4;
`else
    exp_w = w8(14'h3E00, 14'h0001, EOB, EOB, EOB, EOB, EOB, EOB);
    exp_low = 2;
`endif
    apply_reset();
    clear_blk();
    blk[63] = 8'h01;
    rdy_low = 0;
    cnt_en = 1'b1;
    run_block(0);
    cnt_en = 1'b0;
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL last_count: got %0d want 1", wlog.size()); end
    if (wlog.size() >= 1) begin
      checks++; if (wlog[0].data !== exp_w) begin errors++; $display("FAIL last_data: got %h want %h", wlog[0].data, exp_w); end
      checks++; if (wlog[0].done !== 1'b1) begin errors++; $display("FAIL last_done: got %b want 1", wlog[0].done); end
    end
    checks++; if (rdy_low != exp_low) begin errors++; $display("FAIL last_ready_low: got %0d cycles want %0d", rdy_low, exp_low); end
  endtask

  task automatic test_reset_mid_block();
    logic [111:0] exp_w;
    exp_w = w8(EOB, EOB, EOB, EOB, EOB, EOB, EOB, EOB);
    apply_reset();
    for (int i = 0; i < 20; i++) send_coef(i < 5 ? 8'h01 : 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL mid_partial: got %0d writes want 0", wlog.size()); end
    apply_reset();
    clear_blk();
    run_block(0);
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", wlog.size()); end
    if (wlog.size() >= 1) begin
      checks++; if (wlog[0].addr !== 14'd0) begin errors++; $display("FAIL mid_addr: got %0d want 0", wlog[0].addr); end
      checks++; if (wlog[0].data !== exp_w) begin errors++; $display("FAIL mid_data: got %h want %h", wlog[0].data, exp_w); end
    end
  endtask

  task automatic test_back_to_back();
    logic [111:0] exp_a, exp_b;
`ifdef RLE_ZRL_EN
    exp_a = w8(14'h0007, 14'h0F00, 14'h0F00, 14'h0F00, 14'h0EFF, EOB, EOB, EOB);
    exp_b = w8(14'h0302, 14'h0F00, 14'h0080, EOB, EOB, EOB, EOB, EOB);
`else
    exp_a = w8(14'h0007, 14'h3EFF, EOB, EOB, EOB, EOB, EOB, EOB);
    exp_b = w8(14'h0302, 14'h1080, EOB, EOB, EOB, EOB, EOB, EOB);
`endif
    apply_reset();
    clear_blk();
    blk[0] = 8'h07;
    blk[63] = 8'hFF;
    for (int i = 0; i < 64; i++) send_coef(blk[i]);
    clear_blk();
    blk[3] = 8'h02;
    blk[20] = 8'h80;
    run_block(0);
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", wlog.size()); end
    if (wlog.size() >= 2) begin
      checks++; if (wlog[0].data !== exp_a) begin errors++; $display("FAIL b2b_data_a: got %h want %h", wlog[0].data, exp_a); end
      checks++; if (wlog[1].data !== exp_b) begin errors++; $display("FAIL b2b_data_b: got %h want %h", wlog[1].data, exp_b); end
      checks++; if (wlog[0].addr !== 14'd0 || wlog[1].addr !== 14'd1) begin errors++; $display("FAIL b2b_addr: got %0d,%0d want 0,1", wlog[0].addr, wlog[1].addr); end
      checks++; if (wlog[0].done !== 1'b1 || wlog[1].done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b,%b want 1,1", wlog[0].done, wlog[1].done); end
    end
  endtask

  task automatic test_addr_wrap();
    logic [111:0] exp_ones, exp_eob;
    exp_ones = w8(ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE);
    exp_eob  = w8(EOB, EOB, EOB, EOB, EOB, EOB, EOB, EOB);
    apply_reset();
    force dut.addr_cnt = 14'd16382;
    repeat (2) @(negedge clk);
    release dut.addr_cnt;
    clear_blk();
    for (int i = 0; i < 24; i++) blk[i] = 8'h01;
    run_block(0);
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", wlog.size()); end
    if (wlog.size() >= 4) begin
      checks++; if (wlog[0].addr !== 14'd16382 || wlog[0].wrap !== 1'b0) begin errors++; $display("FAIL wrap_w0: got addr=%0d wrap=%b want 16382 0", wlog[0].addr, wlog[0].wrap); end
      checks++; if (wlog[1].addr !== 14'd16383 || wlog[1].wrap !== 1'b0) begin errors++; $display("FAIL wrap_w1: got addr=%0d wrap=%b want 16383 0", wlog[1].addr, wlog[1].wrap); end
      checks++; if (wlog[2].addr !== 14'd0 || wlog[2].wrap !== 1'b1) begin errors++; $display("FAIL wrap_w2: got addr=%0d wrap=%b want 0 1", wlog[2].addr, wlog[2].wrap); end
      checks++; if (wlog[3].addr !== 14'd1 || wlog[3].wrap !== 1'b0) begin errors++; $display("FAIL wrap_w3: got addr=%0d wrap=%b want 1 0", wlog[3].addr, wlog[3].wrap); end
      checks++; if (wlog[2].data !== exp_ones || wlog[2].done !== 1'b0) begin errors++; $display("FAIL wrap_data2: got %h done=%b want %h 0", wlog[2].data, wlog[2].done, exp_ones); end
      checks++; if (wlog[3].data !== exp_eob || wlog[3].done !== 1'b1) begin errors++; $display("FAIL wrap_data3: got %h done=%b want %h 1", wlog[3].data, wlog[3].done, exp_eob); end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_two_coef();
    test_nine_ones_gaps();
    test_last_only();
    test_reset_mid_block();
    test_back_to_back();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle_word_packer.md
RLE_WORD_PACKER -- requirements
Module: rle_word_packer

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  synchronous, active-low reset; clock clk.
REQ-003 coef_in  input  8  quantised coefficient in zig-zag order, two's complement.
REQ-004 coef_valid  input  1  coef_in is valid this cycle.
REQ-005 coef_ready  output  1  packer accepts coef_in this cycle; transfer occurs when coef_valid and coef_ready are both high.
REQ-006 wr_en  output  1  one-cycle write strobe to the 16384x112 coefficient SRAM.
REQ-007 wr_addr  output  14  SRAM word address for the current write.
REQ-008 wr_data  output  112  packed word: slot k (k=1..8) is run at [111-14(k-1) -: 6] and level at [105-14(k-1) -: 8].
REQ-009 blk_done  output  1  one-cycle pulse, coincident with the wr_en of the word holding a block's EOB.
REQ-010 addr_wrap  output  1  one-cycle pulse when wr_addr advances from 16383 to 0.

Function
REQ-011 A block is exactly 64 accepted coefficients, positions 0..63; a position counter (6 bit) tracks them.
REQ-012 A pair (run, level) advances position by run+1: run zeros are skipped, then level is placed.
REQ-013 A zero coefficient increments a 6-bit zero-run counter and emits nothing, except as stated in REQ-016/REQ-019.
REQ-014 A nonzero coefficient emits (run counter, coef_in) and clears the run counter.
REQ-015 The EOB pair is (6'h3F, 8'h00); run value 63 is reserved for EOB.
REQ-016 After position 63, the packer emits EOB; trailing zeros produce no pairs.
REQ-017 Pairs fill slots 1..8 in order; a word is written when slot 8 fills or when EOB is placed.
REQ-018 On EOB, unfilled slots are padded with EOB pairs in the same write; the next block starts at slot 1 of a new word.
REQ-019 A run that cannot be encoded in one pair produces the extra pairs defined in REQ-029/REQ-030.
REQ-020 FSM states:
- ACCEPT: coef_ready=1.
- EMIT2: coef_ready=0; emits one queued pair (split pair, level pair or EOB).
- ACCEPT goes to EMIT2 whenever one coefficient yields more than one pair.
- EMIT2 returns to ACCEPT when the queue is empty.
REQ-021 At most one pair is packed per cycle.
REQ-022 Latency: wr_en/wr_data/wr_addr are registered and assert the cycle after the filling pair is packed.
REQ-023 wr_addr starts at 0 and increments by 1 after each write; it wraps from 16383 to 0 and pulses addr_wrap in the cycle of the wrapping write.
REQ-024 coef_valid gaps:
- No state advances.
- A partial word is held indefinitely.
- wr_en stays 0.
REQ-025 wr_data holds its last value when wr_en=0.

Reset
REQ-026 While reset=0 at a clk edge, all of the following clear to 0: coef_ready, wr_en, wr_addr, wr_data, blk_done, addr_wrap, position, run counter, slot index.
REQ-027 FSM returns to ACCEPT; coef_ready=1 in the first cycle after reset is released.
REQ-028 Reset mid-block or mid-word discards the partial word without writing it.

Configuration
REQ-029 With RLE_ZRL_EN defined, a nonzero coefficient preceded by run >= 16 first emits ZRL pairs (15, 8'h00), each consuming 16 positions, until run < 16; it then emits (run, level).
REQ-030 Without RLE_ZRL_EN, runs 0..62 encode directly; run 63 (only coef 63 nonzero) emits (62, 8'h00) then (0, level).

Verification
REQ-031 All-zero block -> one write at addr 0; wr_data = 8 slots of 14'h3F00; blk_done=1.
REQ-032 Block with coef0=5, coef1=-3, rest 0 -> slot1=(0,05), slot2=(0,FD), slots 3-8 EOB; single write.
REQ-033 Block with positions 0..8 all = 1 -> write addr0 with 8 slots of (0,01); write addr1 with (0,01) followed by 7 EOB; blk_done on the second write only.
REQ-034 Block with only coef63=1, without RLE_ZRL_EN -> (62,00),(0,01), then 6 EOB; with RLE_ZRL_EN -> (15,00)x3,(15,01), then 4 EOB; coef_ready low during the extra-pair cycles.
REQ-035 Reset asserted after 20 coefficients of a block -> no write; the next full block writes at addr 0.
REQ-036 Preload wr_addr by streaming 16384 all-zero blocks -> the 16384th write is at addr 16383, the next at addr 0, with addr_wrap=1 on the wrapping write.
